hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 14 +
 rtl/hazard_scoreboard_if.sv | 43 ++++
 rtl/hazard_sb_cell.sv | 37 +++
 rtl/hazard_scoreboard.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and latency encodings for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int LW_DEF   = 3;
  localparam int BYP_DEF  = 1;

  // Cycles until a result reaches ID-stage forwarding
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_SC   = 2;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue/ID/mult-div request bundle and stall responses of the hazard scoreboard.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) ();

  logic          issue_valid;
  logic          issue_wreg;
  logic [AW-1:0] issue_rd;
  logic [LW-1:0] issue_lat;
  logic          flush;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic          id_is_branch;
  logic          id_uses_hilo;
  logic          md_issue;
  logic          md_done;
  logic          perf_clr;
  logic          stall;
  logic          stall_data;
  logic          stall_br;
  logic          stall_hilo;
  logic [31:0]   stall_cycles;

  modport master (
    output issue_valid, issue_wreg, issue_rd, issue_lat, flush,
           id_rs, id_rt, id_rs_used, id_rt_used, id_is_branch, id_uses_hilo,
           md_issue, md_done, perf_clr,
    input  stall, stall_data, stall_br, stall_hilo, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_wreg, issue_rd, issue_lat, flush,
           id_rs, id_rt, id_rs_used, id_rt_used, id_is_branch, id_uses_hilo,
           md_issue, md_done, perf_clr,
    output stall, stall_data, stall_br, stall_hilo, stall_cycles
  );

endinterface

// File: rtl/hazard_sb_cell.sv
// One register's result countdown: load with max(decremented, latency), count down, flag nonzero.
module hazard_sb_cell #(
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [LW-1:0] lat,
  output logic [LW-1:0] cnt,
  output logic          busy
);

  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;
  logic [LW-1:0] dec;

  // A younger write never shortens the wait left by an older in-flight one
  always_comb begin
    dec   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    cnt_d = dec;
    if (load && (lat > dec)) begin
      cnt_d = lat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-GPR result countdowns, HI/LO busy flag and a stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int LW   = LW_DEF,
  parameter int BYP  = BYP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);

  logic [NREG-1:0][LW-1:0] cnt;
  logic [NREG-1:0]         busy;
  logic                    accept;
  logic [LW-1:0]           rs_cnt;
  logic [LW-1:0]           rt_cnt;
  logic                    rs_live;
  logic                    rt_live;
  logic                    stall_data;
  logic                    stall_br;
  logic                    stall_hilo;
  logic                    stall;
  logic                    hilo_busy_q;
  logic                    hilo_busy_d;
  logic [31:0]             stall_cycles_q;
  logic [31:0]             stall_cycles_d;

  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  assign accept = bus.issue_valid & bus.issue_wreg & (bus.issue_rd != '0) &
                  ~bus.flush & ~stall;

  for (genvar r = 1; r < NREG; r++) begin : g_cell
    hazard_sb_cell #(.LW(LW)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept && (bus.issue_rd == AW'(r))),
      .lat   (bus.issue_lat),
      .cnt   (cnt[r]),
      .busy  (busy[r])
    );
  end

  // Stalls are gated by rst_n so they drop the moment reset asserts
  always_comb begin
    rs_cnt     = cnt[bus.id_rs];
    rt_cnt     = cnt[bus.id_rt];
    rs_live    = bus.id_rs_used && (bus.id_rs != '0);
    rt_live    = bus.id_rt_used && (bus.id_rt != '0);
    stall_data = 1'b0;
    stall_br   = 1'b0;
    stall_hilo = 1'b0;
    if (bus.id_is_branch) begin
      stall_br = (rs_live && busy[bus.id_rs]) || (rt_live && busy[bus.id_rt]);
    end else begin
      stall_data = (rs_live && (rs_cnt > LW'(BYP))) || (rt_live && (rt_cnt > LW'(BYP)));
    end
    stall_hilo = bus.id_uses_hilo && hilo_busy_q && !bus.md_done;
    stall      = rst_n && (stall_data || stall_br || stall_hilo);
    stall_data = rst_n && stall_data;
    stall_br   = rst_n && stall_br;
    stall_hilo = rst_n && stall_hilo;
  end

  // md_issue wins over md_done so back-to-back mult/div keeps HI/LO busy
  always_comb begin
    hilo_busy_d = hilo_busy_q;
    if (bus.md_issue) begin
      hilo_busy_d = 1'b1;
    end else if (bus.md_done) begin
      hilo_busy_d = 1'b0;
    end
    stall_cycles_d = stall_cycles_q;
    if (bus.perf_clr) begin
      stall_cycles_d = '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hilo_busy_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      hilo_busy_q    <= hilo_busy_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.stall_data   = stall_data;
  assign bus.stall_br     = stall_br;
  assign bus.stall_hilo   = stall_hilo;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, reset/perf sequences, randomized model compare.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int LW   = 3;
  localparam int BYP  = 1;
  localparam int NVEC = 31;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  hazard_scoreboard_if #(.AW(AW), .LW(LW)) sb ();

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .LW(LW), .BYP(BYP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv, wr, fl;
    logic [AW-1:0] rd, rs, rt;
    logic [LW-1:0] lat;
    logic          rsu, rtu, br, hilo, mdi, mdd;
    logic          ed, eb, eh;
  } vec_t;

  vec_t tbl [NVEC];

  // Reference model state: cycles left per register, HI/LO flag, stall count
  int          m_cnt [NREG];
  bit          m_busy;
  longint      m_sc;

  function automatic vec_t mk(int iv, int wr, int rd, int lat, int fl,
                              int rs, int rt, int rsu, int rtu, int br,
                              int hilo, int mdi, int mdd, int ed, int eb, int eh);
    vec_t v;
    v.iv = 1'(iv);   v.wr = 1'(wr);   v.rd = AW'(rd);   v.lat = LW'(lat);
    v.fl = 1'(fl);   v.rs = AW'(rs);  v.rt = AW'(rt);
    v.rsu = 1'(rsu); v.rtu = 1'(rtu); v.br = 1'(br);    v.hilo = 1'(hilo);
    v.mdi = 1'(mdi); v.mdd = 1'(mdd);
    v.ed = 1'(ed);   v.eb = 1'(eb);   v.eh = 1'(eh);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sb.issue_valid  = v.iv;
    sb.issue_wreg   = v.wr;
    sb.issue_rd     = v.rd;
    sb.issue_lat    = v.lat;
    sb.flush        = v.fl;
    sb.id_rs        = v.rs;
    sb.id_rt        = v.rt;
    sb.id_rs_used   = v.rsu;
    sb.id_rt_used   = v.rtu;
    sb.id_is_branch = v.br;
    sb.id_uses_hilo = v.hilo;
    sb.md_issue     = v.mdi;
    sb.md_done      = v.mdd;
    sb.perf_clr     = 1'b0;
  endtask

  task automatic idleInputs();
    applyStimulus(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0));
  endtask

  task automatic checkStalls(input string tag, input logic ed, input logic eb, input logic eh);
    checkOutput({tag, ".stall_data"}, 32'(sb.stall_data), 32'(ed));
    checkOutput({tag, ".stall_br"},   32'(sb.stall_br),   32'(eb));
    checkOutput({tag, ".stall_hilo"}, 32'(sb.stall_hilo), 32'(eh));
    checkOutput({tag, ".stall"},      32'(sb.stall),      32'(ed | eb | eh));
  endtask

  task automatic doReset();
    idleInputs();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_busy = 1'b0;
    m_sc   = 0;
  endtask

  // One randomized cycle: predict from the model, compare, then advance the model
  task automatic randomCycle(input int n);
    bit any_data, any_br, ed, eb, eh, es, acc;
    int rd, lat;
    sb.issue_valid  = 1'($urandom_range(0, 1));
    sb.issue_wreg   = ($urandom_range(0, 3) != 0);
    sb.issue_rd     = AW'($urandom_range(0, 7));
    sb.issue_lat    = LW'($urandom_range(0, 7));
    sb.flush        = ($urandom_range(0, 7) == 0);
    sb.id_rs        = AW'($urandom_range(0, 7));
    sb.id_rt        = AW'($urandom_range(0, 7));
    sb.id_rs_used   = 1'($urandom_range(0, 1));
    sb.id_rt_used   = 1'($urandom_range(0, 1));
    sb.id_is_branch = ($urandom_range(0, 3) == 0);
    sb.id_uses_hilo = ($urandom_range(0, 3) == 0);
    sb.md_issue     = ($urandom_range(0, 9) == 0);
    sb.md_done      = ($urandom_range(0, 7) == 0);
    sb.perf_clr     = ($urandom_range(0, 29) == 0);
    #1;
    any_data = 1'b0;
    any_br   = 1'b0;
    if (sb.id_rs_used && sb.id_rs != 0) begin
      any_data |= (m_cnt[sb.id_rs] > BYP);
      any_br   |= (m_cnt[sb.id_rs] > 0);
    end
    if (sb.id_rt_used && sb.id_rt != 0) begin
      any_data |= (m_cnt[sb.id_rt] > BYP);
      any_br   |= (m_cnt[sb.id_rt] > 0);
    end
    ed = any_data && !sb.id_is_branch;
    eb = any_br && sb.id_is_branch;
    eh = sb.id_uses_hilo && m_busy && !sb.md_done;
    es = ed | eb | eh;
    checkStalls($sformatf("rnd%0d", n), ed, eb, eh);
    checkOutput($sformatf("rnd%0d.stall_cycles", n), sb.stall_cycles, 32'(m_sc));
    rd  = int'(sb.issue_rd);
    lat = int'(sb.issue_lat);
    acc = sb.issue_valid && sb.issue_wreg && rd != 0 && !sb.flush && !es;
    for (int r = 1; r < NREG; r++) m_cnt[r] = (m_cnt[r] > 0) ? m_cnt[r] - 1 : 0;
    if (acc && lat > m_cnt[rd]) m_cnt[rd] = lat;
    if (sb.md_issue) m_busy = 1'b1;
    else if (sb.md_done) m_busy = 1'b0;
    if (sb.perf_clr) m_sc = 0;
    else if (es && m_sc < 64'hFFFF_FFFF) m_sc = m_sc + 1;
    @(negedge clk);
  endtask

  initial begin
    // iv wr rd lat fl | rs rt rsu rtu br | hilo mdi mdd | ed eb eh
    tbl[0]  = mk(1,1,5,LAT_LOAD,0, 0,0,0,0,0, 0,0,0, 0,0,0);
    tbl[1]  = mk(1,1,9,3,0,        5,0,1,0,0, 0,0,0, 1,0,0);
    tbl[2]  = mk(0,0,0,0,0,        5,9,1,1,0, 0,0,0, 0,0,0);
    tbl[3]  = mk(1,1,8,LAT_ALU,0,  0,0,0,0,0, 0,0,0, 0,0,0);
    tbl[4]  = mk(0,0,0,0,0,        0,8,0,1,1, 0,0,0, 0,1,0);
    tbl[5]  = mk(0,0,0,0,0,        0,8,0,1,1, 0,0,0, 0,0,0);
    tbl[6]  = mk(1,1,8,LAT_ALU,0,  0,0,0,0,0, 0,0,0, 0,0,0);
    tbl[7]  = mk(0,0,0,0,0,        0,8,0,1,0, 0,0,0, 0,0,0);
    tbl[8]  = mk(1,1,0,7,0,        0,0,1,0,0, 0,0,0, 0,0,0);
    tbl[9]  = mk(1,1,3,7,1,        0,0,1,1,1, 0,0,0, 0,0,0);
    tbl[10] = mk(0,0,0,0,0,        3,0,1,0,1, 0,0,0, 0,0,0);
    tbl[11] = mk(1,1,6,LAT_SC,0,   0,0,0,0,0, 0,0,0, 0,0,0);
    tbl[12] = mk(0,0,0,0,0,        6,0,1,0,1, 0,0,0, 0,1,0);
    tbl[13] = mk(0,0,0,0,0,        6,0,1,0,1, 0,0,0, 0,1,0);
    tbl[14] = mk(0,0,0,0,0,        6,0,1,0,1, 0,0,0, 0,0,0);
    tbl[15] = mk(0,0,0,0,0,        0,0,0,0,0, 0,1,0, 0,0,0);
    tbl[16] = mk(0,0,0,0,0,        0,0,0,0,0, 1,0,0, 0,0,1);
    tbl[17] = mk(0,0,0,0,0,        0,0,0,0,0, 1,0,0, 0,0,1);
    tbl[18] = mk(0,0,0,0,0,        0,0,0,0,0, 1,0,1, 0,0,0);
    tbl[19] = mk(0,0,0,0,0,        0,0,0,0,0, 1,0,0, 0,0,0);
    tbl[20] = mk(0,0,0,0,0,        0,0,0,0,0, 1,1,1, 0,0,0);
    tbl[21] = mk(0,0,0,0,0,        0,0,0,0,0, 1,0,0, 0,0,1);
    tbl[22] = mk(0,0,0,0,0,        0,0,0,0,0, 1,0,1, 0,0,0);
    tbl[23] = mk(1,1,7,5,0,        0,0,0,0,0, 1,0,0, 0,0,0);
    tbl[24] = mk(0,0,0,0,0,        7,7,0,0,0, 0,0,0, 0,0,0);
    tbl[25] = mk(0,0,0,0,0,        7,0,1,0,0, 0,0,0, 1,0,0);
    tbl[26] = mk(1,1,7,1,0,        0,0,0,0,0, 0,0,0, 0,0,0);
    tbl[27] = mk(0,0,0,0,0,        7,0,1,0,0, 0,0,0, 1,0,0);
    tbl[28] = mk(0,0,0,0,0,        7,0,1,0,0, 0,0,0, 0,0,0);
    tbl[29] = mk(1,1,2,0,0,        0,0,0,0,0, 0,0,0, 0,0,0);
    tbl[30] = mk(0,0,0,0,0,        2,2,1,1,1, 0,0,0, 0,0,0);

    idleInputs();
    rst_n = 1'b0;
    @(negedge clk);
    applyStimulus(mk(0,0,0,0,0, 5,5,1,1,1, 1,1,0, 0,0,0));
    #1;
    checkStalls("in_reset", 1'b0, 1'b0, 1'b0);
    checkOutput("in_reset.stall_cycles", sb.stall_cycles, 32'd0);
    doReset();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkStalls($sformatf("vec%0d", i), tbl[i].ed, tbl[i].eb, tbl[i].eh);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a countdown
    doReset();
    applyStimulus(mk(1,1,4,3,0, 0,0,0,0,0, 0,0,0, 0,0,0));
    @(negedge clk);
    applyStimulus(mk(0,0,0,0,0, 4,0,1,0,1, 0,0,0, 0,0,0));
    #1;
    checkStalls("rst_pre", 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkStalls("rst_async", 1'b0, 1'b0, 1'b0);
    checkOutput("rst_async.stall_cycles", sb.stall_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkStalls("rst_after", 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Stall counter: ten held stall cycles, clear priority, saturation
    doReset();
    applyStimulus(mk(0,0,0,0,0, 0,0,0,0,0, 0,1,0, 0,0,0));
    @(negedge clk);
    applyStimulus(mk(0,0,0,0,0, 0,0,0,0,0, 1,0,0, 0,0,0));
    repeat (10) @(negedge clk);
    #1;
    checkOutput("perf.count10", sb.stall_cycles, 32'd10);
    checkOutput("perf.stall_hilo", 32'(sb.stall_hilo), 32'd1);
    sb.perf_clr = 1'b1;
    @(negedge clk);
    sb.perf_clr = 1'b0;
    #1;
    checkOutput("perf.clear", sb.stall_cycles, 32'd0);
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    @(negedge clk);
    release dut.stall_cycles_q;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("perf.saturate", sb.stall_cycles, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("perf.hold_sat", sb.stall_cycles, 32'hFFFF_FFFF);

    doReset();
    for (int n = 0; n < 600; n++) begin
      randomCycle(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
